// File: rtl/ama_riscv_alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: requester count,
// ALU operation codes and the bundled operation type.
package ama_riscv_alu_arb_pkg;

  // Number of requesters sharing the ALU and the width of a requester index
  localparam int unsigned ARB_NUM_REQ = 2;
  localparam int unsigned ARB_ID_W    = $clog2(ARB_NUM_REQ);

  // ALU operation codes; codes 11..15 are undefined and yield zero
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SRL    = 4'd3;
  localparam logic [3:0] ALU_SRA    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_XOR    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  // One ALU operation as presented by a requester
  typedef struct packed {
    logic [3:0]  op_sel;
    logic [31:0] a;
    logic [31:0] b;
  } alu_op_t;

endpackage

// File: rtl/ama_riscv_alu.sv
// Purely combinational RV32 integer ALU shared by the arbiter's requesters.
module ama_riscv_alu
  import ama_riscv_alu_arb_pkg::*;
(
  input  logic [3:0]  op_sel_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  logic [4:0] shamt;

  assign shamt = b_i[4:0];

  // Decode the operation; undefined codes produce zero
  always_comb begin
    result_o = 32'h0000_0000;
    case (op_sel_i)
      ALU_ADD:    result_o = a_i + b_i;
      ALU_SUB:    result_o = a_i - b_i;
      ALU_SLL:    result_o = a_i << shamt;
      ALU_SRL:    result_o = a_i >> shamt;
      ALU_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:    result_o = ($signed(a_i) < $signed(b_i)) ? 32'd1 : 32'd0;
      ALU_SLTU:   result_o = (a_i < b_i) ? 32'd1 : 32'd0;
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_OR:     result_o = a_i | b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_PASS_B: result_o = b_i;
      default:    result_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/ama_riscv_alu_arb.sv
// Two-requester arbiter in front of a single ALU. Each requester owns a
// one-entry response slot; a request is accepted only when its slot is empty
// or draining in the same cycle, so a stalled requester never blocks the other.
module ama_riscv_alu_arb
  import ama_riscv_alu_arb_pkg::*;
#(
  parameter int ARB_RR = 1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op_sel,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op_sel,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        grant_id
);

  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [31:0]         rsp0_data_q,  rsp0_data_d;
  logic [31:0]         rsp1_data_q,  rsp1_data_d;
  logic [ARB_ID_W-1:0] ptr_q,        ptr_d;
  logic [ARB_ID_W-1:0] grant_id_q,   grant_id_d;

  logic                elig0, elig1;
  logic                grant_vld;
  logic [ARB_ID_W-1:0] win_id;
  alu_op_t             alu_op;
  logic [31:0]         alu_res;

  // Pick the winner among eligible requesters and steer its operands to the ALU
  always_comb begin
    elig0     = req0_valid & (~rsp0_valid_q | rsp0_ready);
    elig1     = req1_valid & (~rsp1_valid_q | rsp1_ready);
    win_id    = 1'b0;
    if (elig0 && elig1) begin
      win_id = (ARB_RR != 0) ? ptr_q : 1'b0;
    end else if (elig1) begin
      win_id = 1'b1;
    end else begin
      win_id = 1'b0;
    end
    grant_vld  = (elig0 | elig1) & ~rst;
    req0_ready = grant_vld & (win_id == 1'b0);
    req1_ready = grant_vld & (win_id == 1'b1);
    if (win_id == 1'b1) begin
      alu_op = '{op_sel: req1_op_sel, a: req1_a, b: req1_b};
    end else begin
      alu_op = '{op_sel: req0_op_sel, a: req0_a, b: req0_b};
    end
  end

  ama_riscv_alu u_alu (
    .op_sel_i (alu_op.op_sel),
    .a_i      (alu_op.a),
    .b_i      (alu_op.b),
    .result_o (alu_res)
  );

  // Response slot, pointer and debug grant next-state: refill beats drain
  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    ptr_d        = ptr_q;
    grant_id_d   = grant_id_q;
    if (req0_ready) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = alu_res;
    end else if (rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end else begin
      rsp0_valid_d = rsp0_valid_q;
    end
    if (req1_ready) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = alu_res;
    end else if (rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end else begin
      rsp1_valid_d = rsp1_valid_q;
    end
    if (grant_vld) begin
      ptr_d      = ~win_id;
      grant_id_d = win_id;
    end else begin
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
    end
  end

  // State registers with synchronous reset discarding any held results
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= 32'h0000_0000;
      rsp1_data_q  <= 32'h0000_0000;
      ptr_q        <= 1'b0;
      grant_id_q   <= 1'b0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      ptr_q        <= ptr_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign grant_id   = grant_id_q;

endmodule
